// File: rtl/bcd_share_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among four requesters.
// Each winner's 4-bit operand becomes a tens/ones pair that is held until the consumer accepts it.
module bcd_share_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [15:0]      vals,
  input  logic             out_ready,
  output logic [3:0]       grant,
  output logic             out_valid,
  output logic [1:0]       out_id,
  output logic             out_tens,
  output logic [3:0]       out_ones,
  output logic [CNT_W-1:0] conv_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] ptr;
  logic [1:0] id;
  logic [3:0] operand;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       arb;
  logic       accept;
  logic       tens;
  logic [3:0] ones;

  // Search starts at ptr and wraps, so the most recent winner has lowest priority.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign tens   = (operand > 4'd9);
  assign ones   = tens ? (operand - 4'd10) : operand;
  assign accept = out_valid && out_ready;

  always_comb begin
    state_next = state;
    arb        = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          arb        = 1'b1;
          state_next = CONV;
        end
      end
      CONV: state_next = HOLD;
      HOLD: begin
        if (out_ready) begin
          arb        = found;
          state_next = found ? CONV : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= 2'd0;
      id         <= 2'd0;
      operand    <= 4'd0;
      grant      <= 4'd0;
      out_valid  <= 1'b0;
      out_id     <= 2'd0;
      out_tens   <= 1'b0;
      out_ones   <= 4'd0;
      conv_count <= '0;
    end else begin
      grant <= arb ? (4'b0001 << winner) : 4'd0;
      if (arb) begin
        operand <= vals[{winner, 2'b00} +: 4];
        id      <= winner;
        ptr     <= winner + 2'd1;
      end
      if (state == CONV) begin
        out_valid <= 1'b1;
        out_tens  <= tens;
        out_ones  <= ones;
        out_id    <= id;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) conv_count <= conv_count + CNT_W'(1);
    end
  end

endmodule
